// File: rtl/level_pkg.sv
// Shared definitions for the level alarm indicator: FSM encoding and the
// helper that sizes the level counter.
package level_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ALARM  = 2'd1,
    ST_ACKED  = 2'd2
  } state_t;

  // Bits needed to hold a popcount of n inputs (0..n inclusive).
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/level_debounce.sv
// One level switch: two-flop synchronizer followed by a counting debouncer
// that commits a new value after DEBOUNCE_CYC consecutive differing cycles.
module level_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYC - 1);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle of agreement restarts the count, so short glitches never commit.
  always_comb begin
    cnt_d    = 8'd0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/level_alarm_indicator.sv
// Tank level alarm: debounced level switches feed a NORMAL/ALARM/ACKED FSM
// driving a green lamp and a red lamp that blinks until acknowledged.
module level_alarm_indicator
  import level_pkg::*;
#(
  parameter int N_LEVELS     = 6,
  parameter int DEBOUNCE_CYC = 4,
  parameter int BLINK_DIV    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_LEVELS-1:0]                 levels,
  input  logic                                ack,
  output logic                                R,
  output logic                                G,
  output logic [count_width(N_LEVELS)-1:0]    level_count,
  output logic                                full
);

  localparam int          CW        = count_width(N_LEVELS);
  localparam logic [15:0] BCNT_LAST = 16'(BLINK_DIV - 1);

  logic [N_LEVELS-1:0] stable;
  state_t              state_q, state_d;
  logic [15:0]         bcnt_q, bcnt_d;
  logic                blink_q, blink_d;

  for (genvar i = 0; i < N_LEVELS; i++) begin : g_bit
    level_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (levels[i]),
      .stable_o (stable[i])
    );
  end

  assign full = &stable;

  always_comb begin
    level_count = '0;
    for (int i = 0; i < N_LEVELS; i++) begin
      level_count = level_count + CW'(stable[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Losing full always wins over a coincident acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (full) state_d = ST_ALARM;
      ST_ALARM: begin
        if (!full)    state_d = ST_NORMAL;
        else if (ack) state_d = ST_ACKED;
      end
      ST_ACKED:  if (!full) state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (state_q != ST_ALARM && state_d == ST_ALARM) begin
      blink_d = 1'b1;
      bcnt_d  = 16'd0;
    end else if (state_q == ST_ALARM) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d  = 16'd0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= 16'd0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    G = 1'b1;
    R = 1'b0;
    case (state_q)
      ST_ALARM: begin
        G = 1'b0;
        R = blink_q;
      end
      ST_ACKED: begin
        G = 1'b0;
        R = 1'b1;
      end
      default: begin
        G = 1'b1;
        R = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/level_alarm_indicator.md
LEVEL_ALARM_INDICATOR -- requirements
Module: level_alarm_indicator

Interface
REQ-001 Parameter N_LEVELS, default 6, number of level switch inputs (2..32).
REQ-002 Parameter DEBOUNCE_CYC, default 4, consecutive cycles a raw input must differ from its debounced value before the debounced value updates (1..255).
REQ-003 Parameter BLINK_DIV, default 8, cycles per half-period of the red blink (1..65535).
REQ-004 clk  input  1  sole clock, rising-edge; the block has one clock domain.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 levels  input  N_LEVELS  raw switch values, bit i high = level i reached; asynchronous to clk.
REQ-007 ack  input  1  operator acknowledge, sampled each rising edge.
REQ-008 R  output  1  red indicator.
REQ-009 G  output  1  green indicator.
REQ-010 level_count  output  $clog2(N_LEVELS+1)  number of debounced level bits that are high.
REQ-011 full  output  1  high when all debounced level bits are high.

Function
REQ-012 Each levels bit shall pass through a two-flop synchronizer before debouncing; the synchronizer adds 2 cycles of latency.
REQ-013 Per bit: counter cnt_i shall increment each cycle the synchronized bit differs from stable_i and clear to 0 when they are equal.
REQ-014 When the bit still differs and cnt_i == DEBOUNCE_CYC-1, stable_i shall take the synchronized value on that edge, and cnt_i shall clear.
REQ-015 A glitch shorter than DEBOUNCE_CYC cycles after synchronization shall leave stable_i unchanged.
REQ-016 full = &stable.
REQ-017 level_count = popcount(stable).
REQ-018 full and level_count shall be combinational from stable; they change in the same cycle as stable.
REQ-019 The FSM shall have states NORMAL, ALARM and ACKED.
REQ-020 NORMAL -> ALARM on the edge where full==1.
REQ-021 ALARM -> ACKED on the edge where full==1 and ack==1.
REQ-022 ALARM -> NORMAL and ACKED -> NORMAL on the edge where full==0; full==0 takes priority over simultaneous ack.
REQ-023 ack shall have no effect in NORMAL or ACKED.
REQ-024 Outputs are Moore-decoded from the state registers.
REQ-025 In NORMAL: G=1, R=0.
REQ-026 In ACKED: G=0, R=1.
REQ-027 In ALARM: G=0, R=blink.
REQ-028 blink shall be set to 1 and blink counter bcnt cleared to 0 on every entry into ALARM.
REQ-029 In ALARM, bcnt shall increment each cycle; at bcnt == BLINK_DIV-1, blink toggles and bcnt wraps to 0.
REQ-030 End-to-end latency: a raw change held steady produces a state change 2+DEBOUNCE_CYC+1 edges after the first edge that samples it.
REQ-031 G and R shall never be high simultaneously; exactly one is high outside ALARM.

Reset
REQ-032 While rst is high at an edge, the block shall set: synchronizer flops=0, stable=0, all cnt_i=0, state=NORMAL, bcnt=0, blink=0.
REQ-033 Reset values: R=0, G=1, full=0, level_count=0.
REQ-034 rst asserted mid-debounce or in ALARM/ACKED shall discard all progress; after release, full inputs require the complete debounce again.

Structure
REQ-035 State encoding (NORMAL/ALARM/ACKED) and the popcount width function shall live in a shared package level_pkg.
REQ-036 Per-bit synchronizer+debouncer shall be one sub-module, level_debounce, instantiated N_LEVELS times via generate.

Verification
REQ-037 Defaults. Reset, then hold levels=6'b111111 steady. -> full=1 and state=ALARM exactly 7 edges after first sampling edge; R=1, G=0; R toggles every 8 cycles.
REQ-038 Defaults. levels=6'b111111, then bit 3 pulses low for 3 cycles. -> stable unchanged; state stays ALARM; level_count stays 6.
REQ-039 In ALARM, pulse ack for 1 cycle. -> next edge ACKED, R=1 steady, G=0. Then drop levels to 6'b011111. -> NORMAL after debounce; G=1; level_count=5.
REQ-040 In ALARM, drop bit 0 so full falls on the same edge ack=1. -> NORMAL, not ACKED.
REQ-041 Assert rst for 1 cycle while in ACKED with levels all high. -> next cycle R=0, G=1, level_count=0; ALARM re-entered 7 edges after release.
REQ-042 Parameters N_LEVELS=3, DEBOUNCE_CYC=1, BLINK_DIV=1. Levels 3'b111. -> ALARM after 4 edges; R toggles every cycle; level_count width 2 reads 3.
